// File: rtl/mipi_csi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mipi_csi_pkg
// Brief    : CSI data-type codes, scheduler state encoding and beat geometry
// Revision : 1.0
// ============================================================================
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;
    localparam logic [5:0] DT_RAW14 = 6'h2D;

    localparam int BYTES_PER_BEAT = 8;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DROP   = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mipi_csi_rx_depacker_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mipi_csi_rx_depacker_scheduler_if
// Brief    : Header/payload input and depacker/status output bundle
// Revision : 1.0
// ============================================================================
interface mipi_csi_rx_depacker_scheduler_if #(
    parameter int WC_W   = 16,
    parameter int LINE_W = 16
);
    logic              hdr_valid_i;
    logic              hdr_ready_o;
    logic [5:0]        hdr_dt_i;
    logic [WC_W-1:0]   hdr_wc_i;
    logic              payload_valid_i;
    logic [63:0]       payload_i;
    logic              depacker_valid_o;
    logic [63:0]       depacker_data_o;
    logic [2:0]        depacker_type_o;
    logic              frame_valid_o;
    logic [LINE_W-1:0] line_count_o;
    logic              err_short_o;
    logic              err_dt_o;
    logic              busy_o;

    modport master (
        output hdr_valid_i, hdr_dt_i, hdr_wc_i, payload_valid_i, payload_i,
        input  hdr_ready_o, depacker_valid_o, depacker_data_o, depacker_type_o,
        input  frame_valid_o, line_count_o, err_short_o, err_dt_o, busy_o
    );

    modport slave (
        input  hdr_valid_i, hdr_dt_i, hdr_wc_i, payload_valid_i, payload_i,
        output hdr_ready_o, depacker_valid_o, depacker_data_o, depacker_type_o,
        output frame_valid_o, line_count_o, err_short_o, err_dt_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mipi_csi_rx_depacker_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mipi_csi_rx_depacker_scheduler
// Brief    : Gates ceil(WC/8) payload beats per long packet into the RAW
//            depacker, enforces an inter-line idle gap, tracks FS/FE.
// Revision : 1.0
// ============================================================================
module mipi_csi_rx_depacker_scheduler
    import mipi_csi_pkg::*;
#(
    parameter int MIN_GAP = 4,
    parameter int WC_W    = 16,
    parameter int LINE_W  = 16
) (
    input  wire logic clk_i,
    input  wire logic reset_i,
    mipi_csi_rx_depacker_scheduler_if.slave bus
);

    localparam int            CNT_W      = WC_W + 1;
    localparam logic [CNT_W-1:0] c_gap_load = CNT_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dvalid;
    logic [63:0]       r_ddata;
    logic [2:0]        r_dtype;
    logic              r_frame;
    logic [LINE_W-1:0] r_line;
    logic              r_err_short;
    logic              r_err_dt;
    logic              w_hdr_ready;
    logic              w_busy;

    logic              w_hdr_take;
    logic              w_is_raw;
    logic              w_is_long;
    logic [CNT_W-1:0]  w_beats;
    logic              w_last;

    assign w_hdr_take = bus.hdr_valid_i && (r_state == ST_IDLE);
    assign w_is_raw   = (bus.hdr_dt_i == DT_RAW10) || (bus.hdr_dt_i == DT_RAW12) ||
                        (bus.hdr_dt_i == DT_RAW14);
    assign w_is_long  = (bus.hdr_dt_i[5:4] != 2'b00);
    assign w_beats    = ({1'b0, bus.hdr_wc_i} + CNT_W'(BYTES_PER_BEAT - 1)) >> BEAT_SHIFT;
    assign w_last     = (r_cnt == c_one);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_take && (w_is_raw || w_is_long)) begin
                    if (w_beats == '0) begin
                        w_next = ST_GAP;
                    end else begin
                        w_next = w_is_raw ? ST_STREAM : ST_DROP;
                    end
                end
            end
            ST_STREAM, ST_DROP: begin
                // A hole ends the packet: upstream never pauses mid-payload.
                if (!bus.payload_valid_i || w_last) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        w_hdr_ready = (r_state == ST_IDLE);
        w_busy      = (r_state != ST_IDLE);
    end

    // Datapath: one down-counter serves as beat budget and then gap timer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_dvalid    <= 1'b0;
            r_ddata     <= '0;
            r_dtype     <= 3'h3;
            r_frame     <= 1'b0;
            r_line      <= '0;
            r_err_short <= 1'b0;
            r_err_dt    <= 1'b0;
        end else begin
            r_dvalid    <= 1'b0;
            r_err_short <= 1'b0;
            r_err_dt    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_take) begin
                        if (bus.hdr_dt_i == DT_FS) begin
                            r_frame <= 1'b1;
                            r_line  <= '0;
                        end else if (bus.hdr_dt_i == DT_FE) begin
                            r_frame <= 1'b0;
                        end else if (w_is_raw) begin
                            r_dtype <= bus.hdr_dt_i[2:0];
                            r_cnt   <= (w_beats == '0) ? c_gap_load : w_beats;
                        end else if (w_is_long) begin
                            r_err_dt <= 1'b1;
                            r_cnt    <= (w_beats == '0) ? c_gap_load : w_beats;
                        end
                    end
                end
                ST_STREAM: begin
                    if (bus.payload_valid_i) begin
                        r_ddata  <= bus.payload_i;
                        r_dvalid <= 1'b1;
                        if (w_last) begin
                            r_cnt <= c_gap_load;
                            if (r_line != '1) begin
                                r_line <= r_line + LINE_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt - c_one;
                        end
                    end else begin
                        r_err_short <= 1'b1;
                        r_cnt       <= c_gap_load;
                    end
                end
                ST_DROP: begin
                    if (bus.payload_valid_i && !w_last) begin
                        r_cnt <= r_cnt - c_one;
                    end else begin
                        r_cnt <= c_gap_load;
                    end
                end
                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.hdr_ready_o      = w_hdr_ready;
    assign bus.busy_o           = w_busy;
    assign bus.depacker_valid_o = r_dvalid;
    assign bus.depacker_data_o  = r_ddata;
    assign bus.depacker_type_o  = r_dtype;
    assign bus.frame_valid_o    = r_frame;
    assign bus.line_count_o     = r_line;
    assign bus.err_short_o      = r_err_short;
    assign bus.err_dt_o         = r_err_dt;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_depacker_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_csi_rx_depacker_scheduler
// Brief    : Directed table-driven bench for the CSI depacker scheduler
// Revision : 1.0
// ============================================================================
module tb_mipi_csi_rx_depacker_scheduler;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mipi_csi_rx_depacker_scheduler_if #(.WC_W(16), .LINE_W(16)) bus ();

    mipi_csi_rx_depacker_scheduler #(
        .MIN_GAP (4),
        .WC_W    (16),
        .LINE_W  (16)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [5:0]  dt;
        logic [15:0] wc;
        int          off;    // contiguous beats offered after the header
        int          fwd;    // beats expected at the depacker
        logic [2:0]  typ;
        int          es;     // err_short pulses
        int          ed;     // err_dt pulses
        int          busy;   // cycles with hdr_ready low
        logic        frame;
        logic [15:0] line;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int vi, input int k);
        logic [63:0] p;
        p = 64'hC0DE_0000_0000_0000 | (64'(vi) << 16) | 64'(k);
        return p;
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        int  low, fwd, bad, es, ed, k;
        bit  done;
        low = 0; fwd = 0; bad = 0; es = 0; ed = 0; k = 0; done = 0;
        @(negedge clk);
        bus.hdr_valid_i     = 1'b1;
        bus.hdr_dt_i        = v.dt;
        bus.hdr_wc_i        = v.wc;
        bus.payload_valid_i = 1'b0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            if (bus.depacker_valid_o) fwd++;
            if (k >= 1 && k <= v.fwd) begin
                if (!bus.depacker_valid_o || bus.depacker_data_o !== pat(vi, k)) bad++;
            end else if (bus.depacker_valid_o) begin
                bad++;
            end
            if (bus.err_short_o) es++;
            if (bus.err_dt_o) ed++;
            if (bus.hdr_ready_o) done = 1; else low++;
            k++;
            @(negedge clk);
            bus.hdr_valid_i     = 1'b0;
            bus.payload_valid_i = (k <= v.off);
            bus.payload_i       = pat(vi, k);
        end
        bus.payload_valid_i = 1'b0;
        chk($sformatf("v%0d_timeout", vi), 64'(done), 64'd1);
        chk($sformatf("v%0d_fwd_beats", vi), 64'(fwd), 64'(v.fwd));
        chk($sformatf("v%0d_beat_errs", vi), 64'(bad), 64'd0);
        chk($sformatf("v%0d_type", vi), 64'(bus.depacker_type_o), 64'(v.typ));
        chk($sformatf("v%0d_err_short", vi), 64'(es), 64'(v.es));
        chk($sformatf("v%0d_err_dt", vi), 64'(ed), 64'(v.ed));
        chk($sformatf("v%0d_busy_cycles", vi), 64'(low), 64'(v.busy));
        chk($sformatf("v%0d_frame", vi), 64'(bus.frame_valid_o), 64'(v.frame));
        chk($sformatf("v%0d_line", vi), 64'(bus.line_count_o), 64'(v.line));
    endtask

    initial begin
        //            dt     wc      off fwd typ   es ed busy frame line
        vt[0]  = '{6'h00, 16'd0,  0,  0, 3'd3, 0, 0, 0,  1'b1, 16'd0};
        vt[1]  = '{6'h2B, 16'd40, 5,  5, 3'd3, 0, 0, 9,  1'b1, 16'd1};
        vt[2]  = '{6'h2C, 16'd20, 4,  3, 3'd4, 0, 0, 7,  1'b1, 16'd2};
        vt[3]  = '{6'h2D, 16'd64, 5,  5, 3'd5, 1, 0, 10, 1'b1, 16'd2};
        vt[4]  = '{6'h2A, 16'd16, 2,  0, 3'd5, 0, 1, 6,  1'b1, 16'd2};
        vt[5]  = '{6'h2B, 16'd0,  0,  0, 3'd3, 0, 0, 4,  1'b1, 16'd2};
        vt[6]  = '{6'h08, 16'd99, 0,  0, 3'd3, 0, 0, 0,  1'b1, 16'd2};
        vt[7]  = '{6'h30, 16'd24, 1,  0, 3'd3, 0, 1, 6,  1'b1, 16'd2};
        vt[8]  = '{6'h2D, 16'd8,  1,  1, 3'd5, 0, 0, 5,  1'b1, 16'd3};
        vt[9]  = '{6'h01, 16'd0,  0,  0, 3'd5, 0, 0, 0,  1'b0, 16'd3};
        vt[10] = '{6'h2B, 16'd9,  2,  2, 3'd3, 0, 0, 6,  1'b0, 16'd4};
        vt[11] = '{6'h00, 16'd0,  0,  0, 3'd3, 0, 0, 0,  1'b1, 16'd0};

        bus.hdr_valid_i     = 1'b0;
        bus.hdr_dt_i        = '0;
        bus.hdr_wc_i        = '0;
        bus.payload_valid_i = 1'b0;
        bus.payload_i       = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_hdr_ready", 64'(bus.hdr_ready_o), 64'd1);
        chk("rst_dvalid", 64'(bus.depacker_valid_o), 64'd0);
        chk("rst_ddata", bus.depacker_data_o, 64'd0);
        chk("rst_type", 64'(bus.depacker_type_o), 64'd3);
        chk("rst_frame", 64'(bus.frame_valid_o), 64'd0);
        chk("rst_line", 64'(bus.line_count_o), 64'd0);
        chk("rst_errs", 64'({bus.err_short_o, bus.err_dt_o}), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vt[i]);
        end

        // Async reset in the middle of a streamed line
        @(negedge clk);
        bus.hdr_valid_i = 1'b1;
        bus.hdr_dt_i    = 6'h2B;
        bus.hdr_wc_i    = 16'd80;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.hdr_valid_i     = 1'b0;
            bus.payload_valid_i = 1'b1;
            bus.payload_i       = pat(20, k);
        end
        @(posedge clk); #2;
        chk("pre_rst_dvalid", 64'(bus.depacker_valid_o), 64'd1);
        chk("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_dvalid", 64'(bus.depacker_valid_o), 64'd0);
        chk("arst_frame", 64'(bus.frame_valid_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_type", 64'(bus.depacker_type_o), 64'd3);
        @(negedge clk);
        rst = 1'b0;
        bus.payload_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_hdr_ready", 64'(bus.hdr_ready_o), 64'd1);
        chk("post_rst_line", 64'(bus.line_count_o), 64'd0);
        chk("post_rst_dvalid", 64'(bus.depacker_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
